// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and presents
// the fetched word (or an access/misalignment fault) to decode over valid/ready.
module ysyx_24070016_ifu #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
   input  logic            clock,
   input  logic            reset,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            rsp_valid,
   output logic            rsp_ready,
   input  logic [XLEN-1:0] rsp_data,
   input  logic            rsp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_pc
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] inst_q, inst_n;
   logic            fault_q, fault_n;
   logic            drop, drop_n;
   logic            misaligned;

   assign misaligned = (pc[1:0] != 2'b00);
   assign req_addr   = pc;

   // Next-state, PC and payload selection; redirect overrides every other event.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      inst_n  = inst_q;
      fault_n = fault_q;
      drop_n  = drop;
      case (state)
         S_REQ: begin
            if (req_valid && req_ready) begin
               // A handshake cannot be revoked; a same-cycle redirect only marks its response stale.
               state_n = S_WAIT;
               drop_n  = redir_valid;
            end else if (!req_valid && misaligned && !redir_valid) begin
               state_n = S_HOLD;
               inst_n  = '0;
               fault_n = 1'b1;
            end
            if (redir_valid) pc_n = redir_pc;
         end
         S_WAIT: begin
            if (rsp_valid && rsp_ready) begin
               if (drop || redir_valid) begin
                  state_n = S_REQ;
                  drop_n  = 1'b0;
               end else begin
                  state_n = S_HOLD;
                  inst_n  = rsp_err ? '0 : rsp_data;
                  fault_n = rsp_err;
               end
            end else if (redir_valid) begin
               drop_n = 1'b1;
            end
            if (redir_valid) pc_n = redir_pc;
         end
         S_HOLD: begin
            if (redir_valid) begin
               state_n = S_REQ;
               pc_n    = redir_pc;
            end else if (out_valid && out_ready) begin
               state_n = S_REQ;
               pc_n    = pc + XLEN'(4);
            end
         end
         default: state_n = S_REQ;
      endcase
   end

   // State and registered outputs, all derived from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         inst_q    <= '0;
         fault_q   <= 1'b0;
         drop      <= 1'b0;
         req_valid <= 1'b0;
         rsp_ready <= 1'b0;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_pc    <= '0;
         out_fault <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         inst_q    <= inst_n;
         fault_q   <= fault_n;
         drop      <= drop_n;
         req_valid <= (state_n == S_REQ) && (pc_n[1:0] == 2'b00);
         rsp_ready <= (state_n == S_WAIT);
         out_valid <= (state_n == S_HOLD);
         out_inst  <= (state_n == S_HOLD) ? inst_n : '0;
         out_pc    <= (state_n == S_HOLD) ? pc_n : '0;
         out_fault <= (state_n == S_HOLD) && fault_n;
      end
   end

endmodule

// File: tb/tb_ysyx_24070016_ifu.sv
// Bench for the fetch unit: cycle vector table, directed corner sequences,
// then randomized memory/decode/redirect traffic checked against a PC-stream model.
module tb_ysyx_24070016_ifu;

   localparam logic [31:0] RP = 32'h8000_0000;

   logic        clock, reset;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic        out_valid, out_ready, out_fault, redir_valid;
   logic [31:0] req_addr, rsp_data, out_inst, out_pc, redir_pc;

   int passed = 0;
   int total  = 0;

   ysyx_24070016_ifu dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_fault(out_fault),
      .redir_valid(redir_valid), .redir_pc(redir_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst, rq_rdy, rs_vld;
      logic [31:0] rs_data;
      logic        rs_err, o_rdy, rd_vld;
      logic [31:0] rd_pc;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_rr, e_ov;
      logic [31:0] e_inst, e_pc;
      logic        e_f;
   } vec_t;

   vec_t vecs [20];

   logic [31:0] targets [8] = '{32'h8000_0000, 32'h8000_0100, 32'h8000_00E8, 32'h8000_0002,
                               32'h8000_0FF0, 32'hFFFF_FFF8, 32'h0000_0040, 32'h8000_0203};

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic rst, input logic rq, input logic rv, input logic [31:0] rd,
                        input logic re, input logic ordy, input logic dv, input logic [31:0] dp);
      reset = rst; req_ready = rq; rsp_valid = rv; rsp_data = rd; rsp_err = re;
      out_ready = ordy; redir_valid = dv; redir_pc = dp;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0000_0413;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a[7:4] == 4'hF;
   endfunction

   // Random-phase model state
   logic [31:0] model_pc, pend_addr, p_pc, p_inst, exp_inst;
   logic        pending, st_prev, p_f, exp_fault;
   int unsigned dly;
   int          hs;

   initial begin
      vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,RP,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,RP,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b1,RP,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,RP,1'b1,1'b0,32'h0,32'h0,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b1,32'h0000_0413,1'b0,1'b0,1'b0,32'h0,       1'b0,RP,1'b0,1'b1,32'h0000_0413,RP,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,RP,1'b0,1'b1,32'h0000_0413,RP,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,32'h0,               1'b1,32'h8000_0004,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,32'h8000_0004,1'b1,1'b0,32'h0,32'h0,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1,32'hDEAD_BEEF,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h8000_0004,1'b0,1'b1,32'h0,32'h8000_0004,1'b1};
      vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,1'b1,32'h8000_0002,       1'b0,32'h8000_0002,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,32'h8000_0002,1'b0,1'b1,32'h0,32'h8000_0002,1'b1};
      vecs[11] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,32'h8000_0100,       1'b1,32'h8000_0100,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[12] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b1,32'h8000_0200,       1'b0,32'h8000_0200,1'b1,1'b0,32'h0,32'h0,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b1,32'h1111_1111,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h8000_0200,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b1,32'h8000_0200,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,32'hFFFF_FFFC,       1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[16] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,32'hFFFF_FFFC,1'b1,1'b0,32'h0,32'h0,1'b0};
      vecs[17] = '{1'b0,1'b0,1'b1,32'h0010_0093,1'b0,1'b0,1'b0,32'h0,       1'b0,32'hFFFF_FFFC,1'b0,1'b1,32'h0010_0093,32'hFFFF_FFFC,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,32'h0,               1'b1,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0};
      vecs[19] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,RP,                  1'b1,RP,1'b0,1'b0,32'h0,32'h0,1'b0};

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].rst, vecs[i].rq_rdy, vecs[i].rs_vld, vecs[i].rs_data, vecs[i].rs_err,
               vecs[i].o_rdy, vecs[i].rd_vld, vecs[i].rd_pc);
         step();
         chk($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].e_rv));
         chk($sformatf("v%0d_req_addr", i),  req_addr,        vecs[i].e_addr);
         chk($sformatf("v%0d_rsp_ready", i), 32'(rsp_ready), 32'(vecs[i].e_rr));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d_out_inst", i),  out_inst,        vecs[i].e_inst);
         chk($sformatf("v%0d_out_pc", i),    out_pc,          vecs[i].e_pc);
         chk($sformatf("v%0d_out_fault", i), 32'(out_fault), 32'(vecs[i].e_f));
      end

      // Decode stall: payload held, no new request, single advance on release
      idle(); req_ready = 1'b1; step();
      chk("a_wait_rsp_ready", 32'(rsp_ready), 32'd1);
      idle(); rsp_valid = 1'b1; rsp_data = 32'h0000_0413; step();
      idle();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("a_stall_valid", 32'(out_valid), 32'd1);
         chk("a_stall_inst", out_inst, 32'h0000_0413);
         chk("a_stall_pc", out_pc, RP);
         chk("a_stall_no_req", 32'(req_valid), 32'd0);
      end
      out_ready = 1'b1; step();
      chk("a_release_valid", 32'(out_valid), 32'd0);
      chk("a_release_addr", req_addr, 32'h8000_0004);
      idle(); step();
      chk("a_once_addr", req_addr, 32'h8000_0004);
      chk("a_once_req", 32'(req_valid), 32'd1);

      // Redirect while waiting; late response is swallowed
      req_ready = 1'b1; step();
      idle(); redir_valid = 1'b1; redir_pc = 32'h8000_0100; step();
      idle();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("b_drop_rsp_ready", 32'(rsp_ready), 32'd1);
         chk("b_drop_no_out", 32'(out_valid), 32'd0);
      end
      rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; step();
      idle();
      chk("b_after_drop_out", 32'(out_valid), 32'd0);
      chk("b_after_drop_req", 32'(req_valid), 32'd1);
      chk("b_after_drop_addr", req_addr, 32'h8000_0100);

      // Redirect in HOLD together with out_ready: no pc+4
      req_ready = 1'b1; step();
      idle(); rsp_valid = 1'b1; rsp_data = 32'h0000_0093; step();
      chk("c_hold_inst", out_inst, 32'h0000_0093);
      idle(); out_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h8000_0300; step();
      idle(); step();
      chk("c_redir_addr", req_addr, 32'h8000_0300);
      chk("c_redir_out", 32'(out_valid), 32'd0);

      // Access fault, then misaligned redirect with no memory request
      req_ready = 1'b1; step();
      idle(); rsp_valid = 1'b1; rsp_err = 1'b1; rsp_data = 32'h1234_5678; step();
      chk("e_fault", 32'(out_fault), 32'd1);
      chk("e_fault_inst", out_inst, 32'h0);
      chk("e_fault_pc", out_pc, 32'h8000_0300);
      idle(); redir_valid = 1'b1; redir_pc = 32'h8000_0002; step();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("e_mis_no_req", 32'(req_valid), 32'd0);
         step();
      end
      chk("e_mis_fault", 32'(out_fault), 32'd1);
      chk("e_mis_pc", out_pc, 32'h8000_0002);
      chk("e_mis_valid", 32'(out_valid), 32'd1);

      // Reset while a fetch is outstanding
      redir_valid = 1'b1; redir_pc = 32'h8000_0040; step();
      idle(); req_ready = 1'b1; step();
      idle(); reset = 1'b1; step();
      chk("d_rst_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("d_rst_req_valid", 32'(req_valid), 32'd0);
      idle(); rsp_valid = 1'b1; rsp_data = 32'hCAFE_BABE; step();
      chk("d_late_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("d_restart_addr", req_addr, RP);
      step();
      chk("d_late_rsp_ready2", 32'(rsp_ready), 32'd0);
      idle(); req_ready = 1'b1; step();
      idle(); rsp_valid = 1'b1; rsp_data = 32'h0000_0513; step();
      chk("d_restart_inst", out_inst, 32'h0000_0513);
      chk("d_restart_pc", out_pc, RP);
      idle(); out_ready = 1'b1; step();

      // Randomized traffic against the PC-stream model
      idle(); reset = 1'b1; step(); step(); reset = 1'b0;
      model_pc = RP; pending = 1'b0; dly = 0; pend_addr = 32'h0;
      st_prev = 1'b0; p_pc = 32'h0; p_inst = 32'h0; p_f = 1'b0; hs = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         req_ready   = pending ? 1'b0 : ($urandom_range(0, 9) < 7);
         rsp_valid   = pending && (dly == 0);
         rsp_data    = pending ? mem_word(pend_addr) : $urandom;
         rsp_err     = pending ? mem_err(pend_addr) : 1'b0;
         out_ready   = ($urandom_range(0, 9) < 6);
         redir_valid = ($urandom_range(0, 19) == 0);
         redir_pc    = targets[$urandom_range(0, 7)];

         if (st_prev) begin
            chk("r_stall_valid", 32'(out_valid), 32'd1);
            chk("r_stall_pc", out_pc, p_pc);
            chk("r_stall_inst", out_inst, p_inst);
            chk("r_stall_fault", 32'(out_fault), 32'(p_f));
         end
         if (rsp_ready) chk("r_rsp_ready_has_req", 32'(pending), 32'd1);
         if (req_valid) begin
            chk("r_one_outstanding", 32'(pending), 32'd0);
            chk("r_req_addr", req_addr, model_pc);
         end
         if (rsp_valid && rsp_ready) pending = 1'b0;
         else if (pending && dly != 0) dly--;
         if (req_valid && req_ready) begin
            pending   = 1'b1;
            pend_addr = req_addr;
            dly       = $urandom_range(0, 3);
         end
         if (out_valid && out_ready && !redir_valid) begin
            exp_fault = (model_pc[1:0] != 2'b00) || mem_err(model_pc);
            exp_inst  = exp_fault ? 32'h0 : mem_word(model_pc);
            chk("r_out_pc", out_pc, model_pc);
            chk("r_out_fault", 32'(out_fault), 32'(exp_fault));
            chk("r_out_inst", out_inst, exp_inst);
            model_pc = model_pc + 32'd4;
            hs++;
         end
         if (redir_valid) model_pc = redir_pc;

         st_prev = out_valid && !out_ready && !redir_valid;
         p_pc = out_pc; p_inst = out_inst; p_f = out_fault;
         step();
      end
      chk("r_progress", 32'(hs >= 100), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
